// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_e;

  localparam int unsigned BCD_DIGIT_W = 4;

  // Minimal decimal digit count for an unsigned value of the given width:
  // ceil(width * log10(2)). 2^width is never a power of ten for width >= 1.
  function automatic int unsigned bcd_digits_for(int unsigned width);
    longint unsigned scaled;
    if (width == 0) return 1;
    scaled = 64'(width) * 64'd30103 + 64'd99999;
    return 32'(scaled / 64'd100000);
  endfunction

endpackage

// File: rtl/bcd_seq_converter_if.sv
// Request/result handshake bundle for bcd_seq_converter.
// BCD_SIGNED_EN adds the registered sign result.
interface bcd_seq_converter_if
  import bcd_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 8,
  parameter int unsigned DIGITS   = 3
);

  logic                          in_valid;
  logic                          in_ready;
  logic [IN_WIDTH-1:0]           in_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd;
  logic                          overflow;
`ifdef BCD_SIGNED_EN
  logic                          sign;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, bcd, overflow, sign
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, bcd, overflow, sign
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, bcd, overflow
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, bcd, overflow
  );
`endif

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) digit_o = digit_i + 4'd3;
  end

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter, one input bit per clock (shift-and-add-3).
// BCD_SIGNED_EN: treat in_data as two's complement and report a sign bit.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 8,
  parameter int unsigned DIGITS   = 3
) (
  input logic               clk,
  input logic               reset,
  bcd_seq_converter_if.slave bus
);

  localparam int unsigned DigW = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CntW = $clog2(IN_WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(IN_WIDTH - 1);
  // With enough digits nothing can ever leave the top digit.
  localparam bit Undersized = DIGITS < bcd_digits_for(IN_WIDTH);

  bcd_state_e          state_q;
  logic [IN_WIDTH-1:0] bin_q;
  logic [DigW-1:0]     dig_q;
  logic [CntW-1:0]     cnt_q;
  logic                sticky_q;
  logic                out_valid_q;
  logic [DigW-1:0]     bcd_q;
  logic                overflow_q;

  logic [DigW-1:0]          dig_adj;
  logic [DigW+IN_WIDTH-1:0] shift_d;
  logic [DigW-1:0]          dig_next;
  logic [IN_WIDTH-1:0]      bin_next;
  logic                     carry_out;
  logic [IN_WIDTH-1:0]      load_val;
  logic                     in_ready;
  logic                     accept;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i(dig_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o(dig_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign shift_d   = {dig_adj[DigW-2:0], bin_q, 1'b0};
  assign dig_next  = shift_d[DigW+IN_WIDTH-1:IN_WIDTH];
  assign bin_next  = shift_d[IN_WIDTH-1:0];
  assign carry_out = Undersized ? dig_adj[DigW-1] : 1'b0;

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

`ifdef BCD_SIGNED_EN
  logic neg_q;
  logic sign_q;

  // Unary minus of the most negative value wraps to 2^(IN_WIDTH-1), which is
  // the correct magnitude when read as unsigned.
  assign load_val = bus.in_data[IN_WIDTH-1] ? -bus.in_data : bus.in_data;
  assign bus.sign = sign_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      neg_q  <= 1'b0;
      sign_q <= 1'b0;
    end else begin
      if (accept) neg_q <= bus.in_data[IN_WIDTH-1];
      if (state_q == SHIFT && cnt_q == LastCnt) sign_q <= neg_q;
    end
  end
`else
  assign load_val = bus.in_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      dig_q       <= '0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      bcd_q       <= '0;
      overflow_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (state_q == DONE && bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
          // Accept may coincide with draining a finished result.
          if (accept) begin
            bin_q    <= load_val;
            dig_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          dig_q    <= dig_next;
          bin_q    <= bin_next;
          sticky_q <= sticky_q | carry_out;
          cnt_q    <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            bcd_q       <= dig_next;
            overflow_q  <= sticky_q | carry_out;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.bcd       = bcd_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed bench for bcd_seq_converter: three configurations (8/3, 16/5, 8/2).
module tb_bcd_seq_converter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bcd_seq_converter_if #(.IN_WIDTH(8),  .DIGITS(3)) ia ();
  bcd_seq_converter_if #(.IN_WIDTH(16), .DIGITS(5)) ib ();
  bcd_seq_converter_if #(.IN_WIDTH(8),  .DIGITS(2)) ic ();

  bcd_seq_converter #(.IN_WIDTH(8),  .DIGITS(3)) u_a (.clk(clk), .reset(reset), .bus(ia.slave));
  bcd_seq_converter #(.IN_WIDTH(16), .DIGITS(5)) u_b (.clk(clk), .reset(reset), .bus(ib.slave));
  bcd_seq_converter #(.IN_WIDTH(8),  .DIGITS(2)) u_c (.clk(clk), .reset(reset), .bus(ic.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input int w, input logic v, input logic [15:0] d);
    case (w)
      0:       begin ia.in_valid = v; ia.in_data = d[7:0]; end
      1:       begin ib.in_valid = v; ib.in_data = d;      end
      default: begin ic.in_valid = v; ic.in_data = d[7:0]; end
    endcase
  endtask

  task automatic set_ordy(input int w, input logic r);
    case (w)
      0:       ia.out_ready = r;
      1:       ib.out_ready = r;
      default: ic.out_ready = r;
    endcase
  endtask

  task automatic peek(input int w, output logic ir, output logic ov, output logic [19:0] b,
                      output logic of);
    case (w)
      0:       begin ir = ia.in_ready; ov = ia.out_valid; b = 20'(ia.bcd); of = ia.overflow; end
      1:       begin ir = ib.in_ready; ov = ib.out_valid; b = ib.bcd;      of = ib.overflow; end
      default: begin ir = ic.in_ready; ov = ic.out_valid; b = 20'(ic.bcd); of = ic.overflow; end
    endcase
  endtask

  // Counts edges until out_valid, bounded so a stuck DUT still reaches the summary.
  task automatic wait_valid(input int w, output int lat);
    logic ir, ov, of;
    logic [19:0] b;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      peek(w, ir, ov, b, of);
    end while (!ov && lat < 200);
  endtask

  task automatic convert(input int w, input logic [15:0] d, input logic [19:0] exp_bcd,
                         input logic exp_of, input int exp_lat, input string tag);
    logic ir, ov, of;
    logic [19:0] b;
    int lat;
    peek(w, ir, ov, b, of);
    check_eq({tag, "/in_ready"}, 64'(ir), 64'd1);
    set_in(w, 1'b1, d);
    @(posedge clk);
    #1;
    set_in(w, 1'b0, ~d);
    wait_valid(w, lat);
    check_eq({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    peek(w, ir, ov, b, of);
    check_eq({tag, "/bcd"}, 64'(b), 64'(exp_bcd));
    check_eq({tag, "/overflow"}, 64'(of), 64'(exp_of));
    set_ordy(w, 1'b1);
    @(posedge clk);
    #1;
    set_ordy(w, 1'b0);
    peek(w, ir, ov, b, of);
    check_eq({tag, "/valid_drop"}, 64'(ov), 64'd0);
  endtask

  initial begin
    logic ir, ov, of;
    logic [19:0] b;
    int lat;
    logic seen;

    reset = 1'b1;
    for (int w = 0; w < 3; w++) begin
      set_in(w, 1'b0, 16'd0);
      set_ordy(w, 1'b0);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int w = 0; w < 3; w++) begin
      peek(w, ir, ov, b, of);
      check_eq("rst/in_ready", 64'(ir), 64'd1);
      check_eq("rst/out_valid", 64'(ov), 64'd0);
      check_eq("rst/bcd", 64'(b), 64'd0);
      check_eq("rst/overflow", 64'(of), 64'd0);
    end
    reset = 1'b0;

`ifdef BCD_SIGNED_EN
    convert(0, 16'h0080, 20'h00128, 1'b0, 8, "s_neg128");
    check_eq("s_neg128/sign", 64'(ia.sign), 64'd1);
    convert(0, 16'h007F, 20'h00127, 1'b0, 8, "s_pos127");
    check_eq("s_pos127/sign", 64'(ia.sign), 64'd0);
    convert(0, 16'h00FF, 20'h00001, 1'b0, 8, "s_neg1");
    check_eq("s_neg1/sign", 64'(ia.sign), 64'd1);
`else
    convert(0, 16'd255,   20'h00255, 1'b0, 8,  "a255");
    convert(0, 16'd0,     20'h00000, 1'b0, 8,  "a0");
    convert(1, 16'd65535, 20'h65535, 1'b0, 16, "b65535");
    convert(1, 16'd10000, 20'h10000, 1'b0, 16, "b10000");
    convert(2, 16'd100,   20'h00000, 1'b1, 8,  "c100");
    convert(2, 16'd99,    20'h00099, 1'b0, 8,  "c99");
`endif

    // Backpressure: result must hold while requests keep arriving.
    set_in(0, 1'b1, 16'd123);
    @(posedge clk);
    #1;
    set_in(0, 1'b0, 16'd0);
    wait_valid(0, lat);
    check_eq("bp/latency", 64'(lat), 64'd8);
    for (int i = 0; i < 20; i++) begin
      set_in(0, 1'b1, 16'(i * 7 + 1));
      @(posedge clk);
      #1;
      peek(0, ir, ov, b, of);
      check_eq("bp/bcd_hold", 64'(b), 64'h123);
      check_eq("bp/in_ready_low", 64'(ir), 64'd0);
      check_eq("bp/valid_hold", 64'(ov), 64'd1);
    end
    set_in(0, 1'b1, 16'd77);
    set_ordy(0, 1'b1);
    #1;
    peek(0, ir, ov, b, of);
    check_eq("bp/in_ready_follow", 64'(ir), 64'd1);
    @(posedge clk);
    #1;
    set_in(0, 1'b0, 16'd0);
    set_ordy(0, 1'b0);
    peek(0, ir, ov, b, of);
    check_eq("bp/drain_drop", 64'(ov), 64'd0);
    wait_valid(0, lat);
    check_eq("bp2/latency", 64'(lat), 64'd8);
    peek(0, ir, ov, b, of);
    check_eq("bp2/bcd", 64'(b), 64'h077);
    set_ordy(0, 1'b1);
    @(posedge clk);
    #1;
    set_ordy(0, 1'b0);

    // Reset three cycles into SHIFT discards the conversion.
    set_in(0, 1'b1, 16'd100);
    @(posedge clk);
    #1;
    set_in(0, 1'b0, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    peek(0, ir, ov, b, of);
    check_eq("rst_mid/in_ready", 64'(ir), 64'd1);
    check_eq("rst_mid/out_valid", 64'(ov), 64'd0);
    check_eq("rst_mid/bcd", 64'(b), 64'd0);
    check_eq("rst_mid/overflow", 64'(of), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      peek(0, ir, ov, b, of);
      if (ov) seen = 1'b1;
    end
    check_eq("rst_mid/no_valid", 64'(seen), 64'd0);
    convert(0, 16'd42, 20'h00042, 1'b0, 8, "a42");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
